// File: rtl/pe_addr_sequencer.sv
// -----------------------------------------------------------------------------
// pe_addr_sequencer
//
// Sequences weight (W), input (I), output-accumulate (O_In) and output-read
// (O_Out) PE addresses for a PE array. A job is started by a start pulse in
// IDLE and runs cfg_blocks input blocks. Each block is I_GROUP accepted steps.
// step_en stalls the address counters cycle by cycle. O_Out is O_In delayed by
// the fixed PE result latency OUT_LAT. When the last step has been accepted,
// the sequencer drains that delay line and then pulses done.
//
// Optional feature macro: PE_SEQ_STRIDE_EN
//   Defined   : adds input cfg_i_stride. It is latched on start, and i_addr
//               advances by that stride mod I_GROUP. A stride of 0 is used as 1.
//   Undefined : i_addr advances by 1, so it always equals the step index.
//
// Ports
//   clk          in   1          clock, all state on rising edge
//   aclr_n       in   1          asynchronous active-low reset
//   sclr         in   1          synchronous clear, same effect as reset
//   start        in   1          job start pulse, sampled only in IDLE
//   cfg_blocks   in   BLK_CNT_W  block count, latched on accepted start
//   step_en      in   1          advance enable, 0 stalls all counters
//   cfg_i_stride in   I_ADDR_W   input address stride (PE_SEQ_STRIDE_EN only)
//   w_addr       out  W_ADDR_W   current weight PE address
//   w_vld        out  1          w_addr valid this cycle
//   i_addr       out  I_ADDR_W   current input PE address
//   i_vld        out  1          i_addr valid this cycle
//   o_in_addr    out  O_ADDR_W   current output-accumulate PE address
//   o_in_vld     out  1          o_in_addr valid this cycle
//   o_out_addr   out  O_ADDR_W   o_in_addr delayed OUT_LAT cycles
//   o_out_vld    out  1          o_in_vld delayed OUT_LAT cycles
//   blk_idx      out  BLK_CNT_W  index of block in progress
//   busy         out  1          sequencer not idle
//   done         out  1          one-cycle pulse at job end
// -----------------------------------------------------------------------------
module pe_addr_sequencer #(
    parameter int W_GROUP   = 4,
    parameter int O_GROUP   = 4,
    parameter int I_GROUP   = W_GROUP + O_GROUP - 1,
    parameter int W_ADDR_W  = 2,
    parameter int O_ADDR_W  = 2,
    parameter int I_ADDR_W  = 3,
    parameter int BLK_CNT_W = 4,
    parameter int OUT_LAT   = 2
) (
    input  logic                 clk,
    input  logic                 aclr_n,
    input  logic                 sclr,
    input  logic                 start,
    input  logic [BLK_CNT_W-1:0] cfg_blocks,
    input  logic                 step_en,
`ifdef PE_SEQ_STRIDE_EN
    input  logic [I_ADDR_W-1:0]  cfg_i_stride,
`endif
    output logic [W_ADDR_W-1:0]  w_addr,
    output logic                 w_vld,
    output logic [I_ADDR_W-1:0]  i_addr,
    output logic                 i_vld,
    output logic [O_ADDR_W-1:0]  o_in_addr,
    output logic                 o_in_vld,
    output logic [O_ADDR_W-1:0]  o_out_addr,
    output logic                 o_out_vld,
    output logic [BLK_CNT_W-1:0] blk_idx,
    output logic                 busy,
    output logic                 done
);

    localparam logic [W_ADDR_W-1:0] W_LAST    = W_ADDR_W'(W_GROUP - 1);
    localparam logic [O_ADDR_W-1:0] O_LAST    = O_ADDR_W'(O_GROUP - 1);
    localparam logic [I_ADDR_W-1:0] STEP_LAST = I_ADDR_W'(I_GROUP - 1);
    localparam logic [I_ADDR_W:0]   I_MOD     = (I_ADDR_W + 1)'(I_GROUP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [BLK_CNT_W-1:0] cfg_blocks_r;
    logic [I_ADDR_W-1:0]  step_idx;
    logic [I_ADDR_W-1:0]  i_stride;

    logic                 start_ok;
    logic                 accept;
    logic                 step_wrap;
    logic                 blk_last;
    logic                 last_step;

    logic [W_ADDR_W-1:0]  w_next;
    logic [O_ADDR_W-1:0]  o_next;
    logic [I_ADDR_W-1:0]  i_next;
    logic [I_ADDR_W:0]    i_sum;
    logic [I_ADDR_W:0]    i_sum_wrapped;

    logic [OUT_LAT-1:0]               pipe_vld;
    logic [OUT_LAT-1:0][O_ADDR_W-1:0] pipe_addr;
    logic                             pipe_busy;

    assign start_ok  = (state == S_IDLE) && start;
    assign accept    = (state == S_RUN) && step_en;
    assign step_wrap = (step_idx == STEP_LAST);
    assign blk_last  = (blk_idx == (cfg_blocks_r - BLK_CNT_W'(1)));
    assign last_step = step_wrap && blk_last;
    assign pipe_busy = |pipe_vld;

    // -------------------------------------------------------------------------
    // Input address stride
    // -------------------------------------------------------------------------
`ifdef PE_SEQ_STRIDE_EN
    logic [I_ADDR_W-1:0] stride_raw;
    logic [I_ADDR_W-1:0] stride_in;
    logic [I_ADDR_W-1:0] stride_r;

    // A zero stride would freeze i_addr, so it is replaced by 1. The stride is
    // reduced mod I_GROUP once, when it is latched. This keeps the per-step
    // adder down to a single conditional subtract.
    always_comb begin
        stride_raw = cfg_i_stride;
        if (stride_raw == '0) begin
            stride_raw = I_ADDR_W'(1);
        end
        stride_in = I_ADDR_W'(32'(stride_raw) % I_GROUP);
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            stride_r <= I_ADDR_W'(1);
        end else if (sclr) begin
            stride_r <= I_ADDR_W'(1);
        end else if (start_ok) begin
            stride_r <= stride_in;
        end
    end

    assign i_stride = stride_r;
`else
    assign i_stride = I_ADDR_W'(1);
`endif

    // -------------------------------------------------------------------------
    // Next address values
    // -------------------------------------------------------------------------
    // Both operands are below I_GROUP, so one subtract is enough to wrap.
    always_comb begin
        w_next        = (w_addr == W_LAST) ? '0 : w_addr + W_ADDR_W'(1);
        o_next        = (o_in_addr == O_LAST) ? '0 : o_in_addr + O_ADDR_W'(1);
        i_sum         = {1'b0, i_addr} + {1'b0, i_stride};
        i_sum_wrapped = i_sum - I_MOD;
        i_next        = (i_sum >= I_MOD) ? i_sum_wrapped[I_ADDR_W-1:0]
                                         : i_sum[I_ADDR_W-1:0];
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state <= S_IDLE;
        end else if (sclr) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (cfg_blocks == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (accept && last_step) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!pipe_busy) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Address, step and block counters
    // -------------------------------------------------------------------------
    // On the final step every counter returns to 0. This means a job always
    // ends, and the next job always starts, with all counters cleared.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            cfg_blocks_r <= '0;
            w_addr       <= '0;
            i_addr       <= '0;
            o_in_addr    <= '0;
            step_idx     <= '0;
            blk_idx      <= '0;
        end else if (sclr) begin
            cfg_blocks_r <= '0;
            w_addr       <= '0;
            i_addr       <= '0;
            o_in_addr    <= '0;
            step_idx     <= '0;
            blk_idx      <= '0;
        end else begin
            if (start_ok) begin
                cfg_blocks_r <= cfg_blocks;
            end
            if (accept) begin
                if (last_step) begin
                    w_addr    <= '0;
                    i_addr    <= '0;
                    o_in_addr <= '0;
                    step_idx  <= '0;
                    blk_idx   <= '0;
                end else begin
                    w_addr    <= w_next;
                    i_addr    <= i_next;
                    o_in_addr <= o_next;
                    if (step_wrap) begin
                        step_idx <= '0;
                        blk_idx  <= blk_idx + BLK_CNT_W'(1);
                    end else begin
                        step_idx <= step_idx + I_ADDR_W'(1);
                    end
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // O_Out delay line
    // -------------------------------------------------------------------------
    // This line models the PE result latency. It shifts every cycle whatever
    // step_en is, so results already in flight still arrive during a stall.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            pipe_vld  <= '0;
            pipe_addr <= '0;
        end else if (sclr) begin
            pipe_vld  <= '0;
            pipe_addr <= '0;
        end else begin
            pipe_vld[0]  <= accept;
            pipe_addr[0] <= o_in_addr;
            for (int k = 1; k < OUT_LAT; k++) begin
                pipe_vld[k]  <= pipe_vld[k-1];
                pipe_addr[k] <= pipe_addr[k-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign w_vld      = accept;
    assign i_vld      = accept;
    assign o_in_vld   = accept;
    assign o_out_vld  = pipe_vld[OUT_LAT-1];
    assign o_out_addr = pipe_addr[OUT_LAT-1];
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

endmodule
